// File: rtl/timer_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank_pkg
//  Description : Shared types and constants for the CSR-mapped timer bank.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package timer_bank_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [31:0] RegT;

    localparam CsrAddrT c_timerAddr      = 12'h400;
    localparam CsrAddrT c_timerBankBase  = c_timerAddr;
    localparam int      c_timerChannels  = 4;
    localparam int      c_timerWidth     = 16;
    localparam int      c_timerPresWidth = 4;

    // Control bit positions for the default field widths.
    localparam int c_timerEnBit   = c_timerPresWidth + c_timerWidth;
    localparam int c_timerModeBit = c_timerEnBit + 1;
    localparam int c_timerPendBit = c_timerEnBit + 2;

    // Wide enough that (top + 1) << maxShift can never overflow.
    function automatic int timerCounterWidth(input int width, input int presWidth);
        return width + (1 << presWidth);
    endfunction

    localparam int c_timerCounterWidth = timerCounterWidth(c_timerWidth, c_timerPresWidth);

    typedef struct packed {
        logic                        pending;
        logic                        mode;
        logic                        enable;
        logic [c_timerWidth-1:0]     counterTop;
        logic [c_timerPresWidth-1:0] prescaler;
    } TimerChT;

endpackage
`default_nettype wire

// File: rtl/timer_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank_if
//  Description : CSR access port and interrupt vector of the timer bank.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
interface timer_bank_if #(
    parameter int CHANNELS = 4
) ();
    import timer_bank_pkg::*;

    logic                csr_we;
    CsrAddrT             csr_addr;
    RegT                 csr_wdata;
    RegT                 csr_rdata;
    logic [CHANNELS-1:0] irq;

    modport master (
        output csr_we, csr_addr, csr_wdata,
        input  csr_rdata, irq
    );

    modport slave (
        input  csr_we, csr_addr, csr_wdata,
        output csr_rdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/timer_bank_channel.sv
`default_nettype none
// ============================================================================
//  Module      : timer_channel
//  Description : One timer channel: config register, counter, FSM, irq flop.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH      = c_timerWidth,
    parameter int PRES_WIDTH = c_timerPresWidth
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_we,
    input  wire RegT  i_wdata,
    output RegT       o_regVal,
    output logic      o_irq
);
    localparam int c_cntWidth = timerCounterWidth(WIDTH, PRES_WIDTH);
    localparam int c_enBit    = PRES_WIDTH + WIDTH;
    localparam int c_modeBit  = c_enBit + 1;
    localparam int c_pendBit  = c_enBit + 2;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]            r_state;
    logic [PRES_WIDTH-1:0] r_pres;
    logic [WIDTH-1:0]      r_top;
    logic                  r_mode;
    logic                  r_pend;
    logic                  r_irq;
    logic [c_cntWidth-1:0] r_counter;
    logic [c_cntWidth-1:0] w_lastCount;

    wire w_unusedWdata = &{1'b0, i_wdata[31:c_pendBit+1]};

    assign w_lastCount = ((c_cntWidth'(r_top) + c_cntWidth'(1)) << r_pres) - c_cntWidth'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_pres    <= '0;
            r_top     <= '0;
            r_mode    <= 1'b0;
            r_pend    <= 1'b0;
            r_irq     <= 1'b0;
            r_counter <= '0;
        end else if (i_we) begin
            // A write overrides a coincident expiry: no pulse, fresh period.
            r_pres    <= i_wdata[PRES_WIDTH-1:0];
            r_top     <= i_wdata[c_enBit-1:PRES_WIDTH];
            r_mode    <= i_wdata[c_modeBit];
            r_pend    <= r_pend & i_wdata[c_pendBit];
            r_state   <= i_wdata[c_enBit] ? c_RUN : c_IDLE;
            r_irq     <= 1'b0;
            r_counter <= '0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                c_RUN: begin
                    if (r_counter == w_lastCount) begin
                        r_counter <= '0;
                        r_pend    <= 1'b1;
                        r_irq     <= 1'b1;
                        if (r_mode) begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_counter <= r_counter + c_cntWidth'(1);
                    end
                end
                default: r_counter <= '0;
            endcase
        end
    end

    always_comb begin
        o_regVal                           = '0;
        o_regVal[PRES_WIDTH-1:0]           = r_pres;
        o_regVal[c_enBit-1:PRES_WIDTH]     = r_top;
        o_regVal[c_enBit]                  = (r_state == c_RUN);
        o_regVal[c_modeBit]                = r_mode;
        o_regVal[c_pendBit]                = r_pend;
    end

    assign o_irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module      : timer_bank
//  Description : N-channel CSR timer bank; address decode and read-back mux.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int      CHANNELS   = c_timerChannels,
    parameter int      WIDTH      = c_timerWidth,
    parameter int      PRES_WIDTH = c_timerPresWidth,
    parameter CsrAddrT BASE_ADDR  = c_timerBankBase
) (
    input wire logic    clk,
    input wire logic    rst_n,
    timer_bank_if.slave bus
);
    logic [CHANNELS-1:0] w_we;
    logic [CHANNELS-1:0] w_irq;
    RegT                 w_regVal [CHANNELS];
    RegT                 w_rdata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        assign w_we[c] = bus.csr_we && (bus.csr_addr == BASE_ADDR + CsrAddrT'(c));

        timer_channel #(
            .WIDTH      (WIDTH),
            .PRES_WIDTH (PRES_WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_we     (w_we[c]),
            .i_wdata  (bus.csr_wdata),
            .o_regVal (w_regVal[c]),
            .o_irq    (w_irq[c])
        );
    end

    // Addresses outside the window read as zero.
    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.csr_addr == BASE_ADDR + CsrAddrT'(c)) begin
                w_rdata = w_regVal[c];
            end
        end
    end

    assign bus.csr_rdata = w_rdata;
    assign bus.irq       = w_irq;

endmodule
`default_nettype wire
